// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the pipelined Y86-64 core: stalls issue on RAW hazards.
// Optional build macro SCOREBOARD_WB_BYPASS_EN lets same-cycle writebacks clear a hazard.
module reg_scoreboard #(
  parameter int NUM_REG  = 16,
  parameter int ADDR_WID = 4,
  parameter int CNT_WID  = 2,
  parameter logic [ADDR_WID-1:0] NONE_ID = {ADDR_WID{1'b1}}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_WID-1:0] srcA,
  input  logic [ADDR_WID-1:0] srcB,
  input  logic [ADDR_WID-1:0] issue_destE,
  input  logic [ADDR_WID-1:0] issue_destM,
  input  logic                wbE_valid,
  input  logic                wbM_valid,
  input  logic [ADDR_WID-1:0] wb_destE,
  input  logic [ADDR_WID-1:0] wb_destM,
  output logic [NUM_REG-1:0]  busy,
  output logic                err
);

  // Two extra bits hold count + 2 without wrapping.
  localparam int SW = CNT_WID + 2;
  localparam logic [SW-1:0] MAX_CNT = SW'((1 << CNT_WID) - 1);

  logic [CNT_WID-1:0] cnt     [NUM_REG];
  logic [CNT_WID-1:0] cnt_nxt [NUM_REG];
  logic [SW-1:0]      inc     [NUM_REG];
  logic [SW-1:0]      dec     [NUM_REG];
  logic [SW-1:0]      sum     [NUM_REG];
  logic [NUM_REG-1:0] busy_nxt;
  logic [NUM_REG-1:0] uflow;
  logic               hazard;
  logic               sat;
  logic               fire;
  logic               src_pending;

  always_comb begin
    hazard      = 1'b0;
    sat         = 1'b0;
    src_pending = 1'b0;
    busy_nxt    = '0;
    uflow       = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      inc[i]     = '0;
      dec[i]     = '0;
      sum[i]     = '0;
      cnt_nxt[i] = cnt[i];
    end

    for (int i = 0; i < NUM_REG; i++) begin
      if (issue_destE != NONE_ID && issue_destE == ADDR_WID'(i)) inc[i] = inc[i] + SW'(1);
      if (issue_destM != NONE_ID && issue_destM == ADDR_WID'(i)) inc[i] = inc[i] + SW'(1);
      if (wbE_valid && wb_destE != NONE_ID && wb_destE == ADDR_WID'(i)) dec[i] = dec[i] + SW'(1);
      if (wbM_valid && wb_destM != NONE_ID && wb_destM == ADDR_WID'(i)) dec[i] = dec[i] + SW'(1);

      if (SW'(cnt[i]) + inc[i] > MAX_CNT) sat = 1'b1;

`ifdef SCOREBOARD_WB_BYPASS_EN
      src_pending = SW'(cnt[i]) > dec[i];
`else
      src_pending = cnt[i] != '0;
`endif
      if (srcA != NONE_ID && srcA == ADDR_WID'(i) && src_pending) hazard = 1'b1;
      if (srcB != NONE_ID && srcB == ADDR_WID'(i) && src_pending) hazard = 1'b1;
    end

    issue_ready = !hazard && !sat && !flush;
    fire        = issue_valid && issue_ready;

    // A flush drops issue and writebacks alike, so it can never raise err.
    for (int i = 0; i < NUM_REG; i++) begin
      sum[i] = SW'(cnt[i]) + (fire ? inc[i] : SW'(0));
      if (flush) begin
        cnt_nxt[i] = '0;
      end else if (sum[i] < dec[i]) begin
        cnt_nxt[i] = '0;
        uflow[i]   = 1'b1;
      end else begin
        cnt_nxt[i] = CNT_WID'(sum[i] - dec[i]);
      end
      busy_nxt[i] = cnt_nxt[i] != '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REG; i++) cnt[i] <= '0;
      busy <= '0;
      err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) cnt[i] <= cnt_nxt[i];
      busy <= busy_nxt;
      err  <= err | (|uflow);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; honours SCOREBOARD_WB_BYPASS_EN when defined.
module tb_reg_scoreboard;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  srcA, srcB, issue_destE, issue_destM;
  logic        wbE_valid, wbM_valid;
  logic [3:0]  wb_destE, wb_destM;
  logic [15:0] busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .srcA        (srcA),
    .srcB        (srcB),
    .issue_destE (issue_destE),
    .issue_destM (issue_destM),
    .wbE_valid   (wbE_valid),
    .wbM_valid   (wbM_valid),
    .wb_destE    (wb_destE),
    .wb_destM    (wb_destM),
    .busy        (busy),
    .err         (err)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, required done", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    srcA        = 4'hF;
    srcB        = 4'hF;
    issue_destE = 4'hF;
    issue_destM = 4'hF;
    wbE_valid   = 1'b0;
    wbM_valid   = 1'b0;
    wb_destE    = 4'hF;
    wb_destM    = 4'hF;
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] de, input logic [3:0] dm);
    issue_valid = 1'b1;
    srcA        = a;
    srcB        = b;
    issue_destE = de;
    issue_destM = dm;
  endtask

  task automatic drive_wb(input logic ve, input logic [3:0] de,
                          input logic vm, input logic [3:0] dm);
    wbE_valid = ve;
    wb_destE  = de;
    wbM_valid = vm;
    wb_destM  = dm;
  endtask

  logic exp_bypass_ready;

  initial begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_bypass_ready = 1'b1;
`else
    exp_bypass_ready = 1'b0;
`endif
    drive_idle();
    RST = 1'b1;
    #1;
    check("ready_in_reset", issue_ready, 1);
    check("busy_reset", busy, 16'h0000);
    check("err_reset", err, 0);
    step();
    step();
    RST = 1'b0;
    step();

    // First issue with no sources, dest 3
    drive_issue(4'hF, 4'hF, 4'h3, 4'hF);
    #1 check("ready_first_issue", issue_ready, 1);
    step();
    drive_idle();
    #1 check("busy_after_issue3", busy, 16'h0008);

    // RAW stall on register 3, released by writeback
    drive_issue(4'h3, 4'hF, 4'hF, 4'hF);
    #1 check("stall_src3", issue_ready, 0);
    step();
    #1 check("stall_src3_held", issue_ready, 0);
    check("busy_stall_held", busy, 16'h0008);
    drive_wb(1'b1, 4'h3, 1'b0, 4'hF);
    #1 check("ready_wb_cycle", issue_ready, 32'(exp_bypass_ready));
    step();
    drive_wb(1'b0, 4'hF, 1'b0, 4'hF);
    #1 check("ready_after_wb", issue_ready, 1);
    check("busy_after_wb3", busy, 16'h0000);
    step();
    drive_idle();

    // popq %rsp style: both dests on register 4
    drive_issue(4'hF, 4'hF, 4'h4, 4'h4);
    step();
    drive_idle();
    #1 check("busy_pop4", busy, 16'h0010);
    drive_wb(1'b1, 4'h4, 1'b0, 4'hF);
    step();
    drive_idle();
    #1 check("busy_pop4_one_wb", busy, 16'h0010);
    drive_wb(1'b0, 4'hF, 1'b1, 4'h4);
    step();
    drive_idle();
    #1 check("busy_pop4_drained", busy, 16'h0000);
    check("err_pop4", err, 0);
    drive_issue(4'hF, 4'hF, 4'h4, 4'h4);
    step();
    drive_idle();
    drive_wb(1'b1, 4'h4, 1'b1, 4'h4);
    step();
    drive_idle();
    #1 check("busy_pop4_dual_wb", busy, 16'h0000);
    check("err_pop4_dual_wb", err, 0);

    // Saturation on register 5
    for (int k = 0; k < 3; k++) begin
      drive_issue(4'hF, 4'hF, 4'h5, 4'hF);
      #1 check("ready_fill5", issue_ready, 1);
      step();
    end
    drive_idle();
    #1 check("busy_full5", busy, 16'h0020);
    drive_issue(4'hF, 4'hF, 4'h5, 4'hF);
    #1 check("sat5", issue_ready, 0);
    step();
    #1 check("sat5_held", issue_ready, 0);
    drive_wb(1'b1, 4'h5, 1'b0, 4'hF);
    #1 check("sat5_wb_cycle", issue_ready, 0);
    step();
    drive_wb(1'b0, 4'hF, 1'b0, 4'hF);
    #1 check("sat5_released", issue_ready, 1);
    step();
    drive_idle();
    drive_wb(1'b1, 4'h5, 1'b1, 4'h5);
    step();
    drive_idle();
    drive_issue(4'hF, 4'hF, 4'h5, 4'hF);
    drive_wb(1'b1, 4'h5, 1'b0, 4'hF);
    #1 check("ready_net_zero", issue_ready, 1);
    step();
    drive_idle();
    #1 check("busy_net_zero5", busy, 16'h0020);
    drive_wb(1'b1, 4'h5, 1'b0, 4'hF);
    step();
    drive_idle();
    #1 check("busy_drain5", busy, 16'h0000);
    check("err_drain5", err, 0);

    // NONE_ID writeback and writeback during flush never underflow
    drive_wb(1'b1, 4'hF, 1'b1, 4'hF);
    step();
    drive_idle();
    #1 check("err_none_wb", err, 0);
    flush = 1'b1;
    drive_wb(1'b1, 4'h9, 1'b0, 4'hF);
    step();
    drive_idle();
    #1 check("err_flush_wb", err, 0);

    // Underflow on register 7
    drive_wb(1'b1, 4'h7, 1'b0, 4'hF);
    step();
    drive_idle();
    #1 check("err_underflow7", err, 1);
    check("busy_underflow7", busy, 16'h0000);

    // Flush with pending 1,2 and a simultaneous issue
    drive_issue(4'hF, 4'hF, 4'h1, 4'h2);
    step();
    drive_idle();
    #1 check("busy_pend12", busy, 16'h0006);
    flush = 1'b1;
    drive_issue(4'hF, 4'hF, 4'h8, 4'hF);
    drive_wb(1'b1, 4'h1, 1'b0, 4'hF);
    #1 check("ready_flush", issue_ready, 0);
    step();
    drive_idle();
    #1 check("busy_after_flush", busy, 16'h0000);
    check("err_held_flush", err, 1);
    step();
    #1 check("busy_flush_dropped", busy, 16'h0000);

    // Asynchronous reset mid-cycle
    drive_issue(4'hF, 4'hF, 4'h6, 4'hF);
    step();
    drive_idle();
    #1 check("busy_pend6", busy, 16'h0040);
    #2 RST = 1'b1;
    #1 check("busy_async_rst", busy, 16'h0000);
    check("err_async_rst", err, 0);
    check("ready_async_rst", issue_ready, 1);
    step();
    RST = 1'b0;
    drive_issue(4'h6, 4'hF, 4'hF, 4'hF);
    #1 check("ready_src6_after_rst", issue_ready, 1);
    step();
    drive_idle();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard that schedules instruction issue against the register file in the pipelined Y86-64 core. Decode presents source and destination register IDs. The block stalls issue while a source still has an outstanding write. Pending writes are counted per register and released when execute or memory results are written back through the destE/destM ports. Register ID 0xF means "no register" and is never tracked.

## Interface
- `NUM_REG`, 16: number of architectural registers tracked.
- `ADDR_WID`, 4: register ID width.
- `CNT_WID`, 2: width of each pending-write counter (max outstanding = 2^CNT_WID-1).
- `NONE_ID`, 4'hF: register ID meaning "no register".

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `flush`  in  1  pipeline flush; clears all pending state.
- `issue_valid`  in  1  decode has an instruction to issue.
- `issue_ready`  out  1  issue permitted this cycle (combinational).
- `srcA`, `srcB`  in  ADDR_WID  source register IDs.
- `issue_destE`, `issue_destM`  in  ADDR_WID  destinations the instruction will write.
- `wbE_valid`, `wbM_valid`  in  1  writeback of destE/destM occurs this cycle.
- `wb_destE`, `wb_destM`  in  ADDR_WID  registers being written back.
- `busy`  out  NUM_REG  bit i = counter i nonzero (registered).
- `err`  out  1  sticky underflow error (registered).

## Operation
- State: one `CNT_WID` counter per register; `err` flag.
- Hazard: `srcA` or `srcB` ≠ NONE_ID with counter ≠ 0.
- Saturation: any issue dest ≠ NONE_ID whose counter + increment > max.
- `issue_ready` = !hazard && !saturation && !flush. It is independent of `issue_valid`.
- Issue fires when `issue_valid && issue_ready`. Each non-NONE dest increments its counter by 1. `issue_destE == issue_destM` (e.g. popq %rsp) increments that counter by 2.
- Each valid writeback with dest ≠ NONE_ID decrements that counter by 1. Both writebacks to the same register decrement it by 2.
- A decrement below 0 clamps the counter at 0 and sets `err`. `err` clears only on `RST`.
- Issue and writeback to the same register in the same cycle apply the net delta: +1 and −1 leaves the counter unchanged.
- `flush` zeroes all counters next edge. Issue and writebacks in the flush cycle are ignored. `err` is held.
- NONE_ID anywhere is ignored: no hazard, no count, no error.

## Timing
- Reset values: all counters 0, `busy` = 0, `err` = 0. `issue_ready` is 1 (no hazard possible) while `RST` is high or after it.
- `RST` asserted mid-operation clears state immediately and asynchronously.
- Counter and `busy` updates take effect at the rising `CLK` edge after the event. `busy` reflects the new counts one cycle after issue or writeback.
- Hazard check uses registered counters only. A writeback in cycle N releases a stalled consumer in cycle N+1. This matches register-file write-at-posedge, read-combinational behaviour.
- Back-to-back issues to the same dest are allowed until saturation.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN`
  - Defined: the hazard check subtracts same-cycle valid writebacks before comparing to 0. A consumer whose source is written back in cycle N issues in cycle N. The register file must then forward valE/valM to valA/valB in that cycle.
  - Undefined: behaviour as in Timing, a one-cycle extra stall after writeback.
  - Counter and `err` behaviour is identical in both builds.

## Test plan
- Reset, then issue srcA=srcB=F, destE=3 → `issue_ready`=1; next cycle `busy`=0x0008.
- Issue dest 3, then srcA=3 with no writeback → `issue_ready`=0 held. `wbE_valid`, `wb_destE`=3 in cycle N → `issue_ready`=1 in N+1; with bypass it is 1 in N.
- Issue with destE=destM=4 (popq %rsp), then one writeback to 4 → `busy[4]`=1. A second writeback → `busy[4]`=0, `err`=0.
- Three issues to dest 5 (count 3), then a fourth issue to 5 → `issue_ready`=0 until a writeback to 5 occurs.
- Writeback to register 7 with counter 0 → `err`=1 next cycle, stays 1 through `flush`, clears on `RST`.
- Registers 1 and 2 pending, assert `flush` with a simultaneous `issue_valid` → `busy`=0 next cycle; the issue is dropped and no counter changes.
